// File: rtl/flit_rr_arbiter_if.sv
// Bundle between the flit sources, the round-robin arbiter and the depacketizer.
// Carries the per-port request side, the registered output side and debug taps.
interface flit_rr_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int FLIT_W    = 48
);
  // Handshakes: a flit moves on a rising clk edge when valid and ready are both 1.
  // A source holds in_flit stable while in_valid && !in_ready; the arbiter holds
  // flit_out stable while flit_valid && !flit_ready. Ready may depend on valid.
  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS*FLIT_W-1:0] in_flit;
  logic [NUM_PORTS-1:0]        in_ready;
  logic [FLIT_W-1:0]           flit_out;
  logic                        flit_valid;
  logic                        flit_ready;
  logic [2:0]                  grant;
  logic                        locked;
  logic                        pkt_done;
  logic                        abort;
  logic                        dbg_state;
  logic [2:0]                  dbg_rr_ptr;

  // master: sources plus depacketizer; slave: the arbiter itself
  modport master (
    output in_valid, in_flit, flit_ready,
    input  in_ready, flit_out, flit_valid, grant, locked, pkt_done, abort,
           dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  in_valid, in_flit, flit_ready,
    output in_ready, flit_out, flit_valid, grant, locked, pkt_done, abort,
           dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/flit_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one flit depacketizer, with a
// watchdog that releases a port whose source stalls mid-packet.
module flit_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int FLIT_W    = 48,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  flit_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  logic [2:0]         rr_ptr;
  logic [2:0]         grant;
  logic [CNT_W-1:0]   idle_cnt;

  logic [7:0]         valid_pad;
  logic [7:0]         ready_pad;
  logic [FLIT_W-1:0]  flit_arr [8];
  logic [FLIT_W-1:0]  sel_flit;
  logic               sel_eop;
  logic [3:0]         cand;
  logic               pick_found;
  logic [2:0]         pick_idx;
  logic [2:0]         next_ptr;
  logic               can_take;
  logic               xfer;
  logic               timeout_hit;

  // Pad the per-port vectors to 8 entries so a 3-bit index is always in range.
  assign valid_pad = 8'(bus.in_valid);

  always_comb begin
    for (int i = 0; i < 8; i++) flit_arr[i] = '0;
    for (int i = 0; i < NUM_PORTS; i++) flit_arr[i] = bus.in_flit[i*FLIT_W +: FLIT_W];
  end

  assign sel_flit = flit_arr[grant];
  assign sel_eop  = (sel_flit[15:0] == 16'hFFFF);
  assign next_ptr = (grant == 3'(NUM_PORTS - 1)) ? 3'd0 : grant + 3'd1;

  // First requester at or above rr_ptr, wrapping back to port 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 4'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NUM_PORTS)) cand = cand - 4'(NUM_PORTS);
      if (!pick_found && valid_pad[cand[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  // The output register can take a new flit when empty or draining this cycle.
  assign can_take = (state == LOCKED) && (!bus.flit_valid || bus.flit_ready);
  assign xfer     = can_take && valid_pad[grant];

  always_comb begin
    ready_pad        = '0;
    ready_pad[grant] = can_take;
  end

  assign bus.in_ready = ready_pad[NUM_PORTS-1:0];

  // Only a silent source counts toward the watchdog, never downstream back-pressure.
  assign timeout_hit = (TIMEOUT > 0) && (state == LOCKED) && !valid_pad[grant] &&
                       (idle_cnt == CNT_W'(TO_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr_ptr         <= 3'd0;
      grant          <= 3'd0;
      idle_cnt       <= '0;
      bus.flit_out   <= '0;
      bus.flit_valid <= 1'b0;
      bus.pkt_done   <= 1'b0;
      bus.abort      <= 1'b0;
    end else begin
      bus.pkt_done <= 1'b0;
      bus.abort    <= 1'b0;

      if (xfer) begin
        bus.flit_out   <= sel_flit;
        bus.flit_valid <= 1'b1;
      end else if (bus.flit_ready) begin
        bus.flit_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            grant    <= pick_idx;
            idle_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (sel_eop) begin
              bus.pkt_done <= 1'b1;
              rr_ptr       <= next_ptr;
              state        <= IDLE;
            end
          end else if (timeout_hit) begin
            bus.abort <= 1'b1;
            idle_cnt  <= '0;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end else if ((TIMEOUT > 0) && !valid_pad[grant]) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant;
  assign bus.locked     = (state == LOCKED);
  assign bus.dbg_state  = state;
  assign bus.dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_flit_rr_arbiter.sv
// Directed bench for flit_rr_arbiter: per-port source queues, an in-order sink
// scoreboard and hand-timed checks of reset, round robin, stalls and the watchdog.
module tb_flit_rr_arbiter;
  localparam int NP = 4;
  localparam int FW = 48;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  flit_rr_arbiter_if #(.NUM_PORTS(NP), .FLIT_W(FW)) bus ();

  flit_rr_arbiter #(.NUM_PORTS(NP), .FLIT_W(FW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- source model and scoreboard state ----------------
  logic [FW-1:0] mem [NP][16];
  int            head [NP];
  int            tail [NP];
  logic [NP-1:0] took;
  bit            manual;
  logic [FW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_err = 0;
  int            n_done = 0;
  int            n_abort = 0;
  int            base_done;
  int            base_abort;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int p, input int s, input bit eop);
    return {8'hA5, 8'(p), 8'(p), 8'(s), (eop ? 16'hFFFF : 16'h0000)};
  endfunction

  task automatic load(input int p, input int s, input bit eop);
    mem[p][tail[p]] = mk(p, s, eop);
    tail[p]++;
  endtask

  task automatic expect_f(input int p, input int s, input bit eop);
    exp_q.push_back(mk(p, s, eop));
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) begin
      head[p] = 0;
      tail[p] = 0;
    end
    took = '0;
    exp_q.delete();
  endtask

  // Sources advance one posedge after the handshake sampled at the negedge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NP; i++) begin
      if (took[i]) head[i]++;
      if (!manual) begin
        bus.in_valid[i]           = (head[i] < tail[i]);
        bus.in_flit[i*FW +: FW]   = mem[i][head[i] % 16];
      end
    end
  end

  // Sink, event counters and handshake sampling.
  always @(negedge clk) begin
    took = bus.in_valid & bus.in_ready;
    if (bus.pkt_done) n_done++;
    if (bus.abort) n_abort++;
    if (bus.flit_valid && bus.flit_ready) begin
      if (exp_q.size() == 0) check("extra_flit", 64'(exp_q.size()), 64'd1);
      else check("flit", bus.flit_out, exp_q.pop_front());
    end
  end

  // ---------------- driver helpers ----------------
  task automatic assert_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    manual  = 1'b0;
    flush();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int c = 0;
    @(negedge clk);
    while (!bus.flit_valid && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(bus.flit_valid), 64'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || bus.locked) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  // ---------------- directed tests ----------------
  initial begin
    for (int p = 0; p < NP; p++)
      for (int j = 0; j < 16; j++) mem[p][j] = '0;
    flush();
    manual         = 1'b1;
    bus.in_valid   = '1;
    bus.in_flit    = {NP{48'h1234_5678_FFFF}};
    bus.flit_ready = 1'b1;

    // 1: reset with every port requesting
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_flit_valid", 64'(bus.flit_valid), 64'd0);
    check("rst_flit_out", bus.flit_out, 64'd0);
    check("rst_locked", 64'(bus.locked), 64'd0);
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_pulses", {bus.pkt_done, bus.abort}, 64'd0);
    bus.in_valid = '0;
    manual       = 1'b0;
    #1 reset_n = 1'b1;

    // 2: single port 2, three flits, exact latency
    @(negedge clk);
    load(2, 1, 0); load(2, 2, 0); load(2, 3, 1);
    expect_f(2, 1, 0); expect_f(2, 2, 0); expect_f(2, 3, 1);
    base_done = n_done;
    @(negedge clk);
    check("t2_idle_locked", 64'(bus.locked), 64'd0);
    @(negedge clk);
    check("t2_locked", 64'(bus.locked), 64'd1);
    check("t2_grant", 64'(bus.grant), 64'd2);
    check("t2_in_ready", 64'(bus.in_ready), 64'b0100);
    check("t2_no_out_yet", 64'(bus.flit_valid), 64'd0);
    @(negedge clk);
    check("t2_first_valid", 64'(bus.flit_valid), 64'd1);
    check("t2_first_payload", 64'(bus.flit_out[31:16]), 64'h0201);
    @(negedge clk);
    check("t2_second_payload", 64'(bus.flit_out[31:16]), 64'h0202);
    @(negedge clk);
    check("t2_eop_payload", 64'(bus.flit_out[31:16]), 64'h0203);
    check("t2_pkt_done", 64'(bus.pkt_done), 64'd1);
    check("t2_unlocked", 64'(bus.locked), 64'd0);
    check("t2_rr_ptr", 64'(bus.dbg_rr_ptr), 64'd3);
    @(negedge clk);
    check("t2_done_pulse_end", 64'(bus.pkt_done), 64'd0);
    check("t2_drained", 64'(bus.flit_valid), 64'd0);
    @(posedge clk);
    check("t2_done_count", 64'(n_done - base_done), 64'd1);

    // 3: round robin among ports 0,1,3, two 2-flit packets each
    assert_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) begin
        if (p != 2) begin
          load(p, 2*r + 1, 0); load(p, 2*r + 2, 1);
          expect_f(p, 2*r + 1, 0); expect_f(p, 2*r + 2, 1);
        end
      end
    end
    base_done = n_done;
    release_reset();
    wait_drain("t3_drain", 100);
    check("t3_done_count", 64'(n_done - base_done), 64'd6);

    // 4: downstream stall of 5 cycles mid-packet, longer than TIMEOUT
    assert_reset();
    for (int s = 1; s <= 4; s++) begin
      load(0, s, s == 4);
      expect_f(0, s, s == 4);
    end
    base_done  = n_done;
    base_abort = n_abort;
    release_reset();
    wait_valid("t4_first_valid", 20);
    check("t4_first_flit", bus.flit_out, mk(0, 1, 0));
    @(posedge clk);
    #1 bus.flit_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_hold_flit", bus.flit_out, mk(0, 2, 0));
      check("t4_hold_valid", 64'(bus.flit_valid), 64'd1);
      check("t4_in_ready_low", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.flit_ready = 1'b1;
    wait_drain("t4_drain", 40);
    check("t4_done_count", 64'(n_done - base_done), 64'd1);
    check("t4_no_abort", 64'(n_abort - base_abort), 64'd0);

    // 5: watchdog releases port 1, waiting port 2 is granted next
    assert_reset();
    load(1, 1, 0);
    load(2, 1, 1);
    expect_f(1, 1, 0);
    expect_f(2, 1, 1);
    base_done  = n_done;
    base_abort = n_abort;
    release_reset();
    wait_valid("t5_first_valid", 20);
    check("t5_first_flit", bus.flit_out, mk(1, 1, 0));
    check("t5_grant1", 64'(bus.grant), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_wait_no_abort", {bus.abort, bus.locked}, 64'b01);
    end
    @(negedge clk);
    check("t5_abort_pulse", 64'(bus.abort), 64'd1);
    check("t5_abort_unlocked", 64'(bus.locked), 64'd0);
    check("t5_abort_not_done", 64'(bus.pkt_done), 64'd0);
    @(negedge clk);
    check("t5_abort_end", 64'(bus.abort), 64'd0);
    check("t5_relocked", 64'(bus.locked), 64'd1);
    check("t5_grant2", 64'(bus.grant), 64'd2);
    wait_drain("t5_drain", 40);
    check("t5_abort_count", 64'(n_abort - base_abort), 64'd1);
    check("t5_done_count", 64'(n_done - base_done), 64'd1);

    // 6: asynchronous reset between clock edges mid-packet
    assert_reset();
    for (int s = 1; s <= 4; s++) begin
      load(1, s, s == 4);
      expect_f(1, s, s == 4);
    end
    release_reset();
    wait_valid("t6_first_valid", 20);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(bus.flit_valid), 64'd0);
    check("t6_async_flit", bus.flit_out, 64'd0);
    check("t6_async_locked", 64'(bus.locked), 64'd0);
    check("t6_async_in_ready", 64'(bus.in_ready), 64'd0);
    check("t6_async_rr_ptr", 64'(bus.dbg_rr_ptr), 64'd0);
    flush();
    load(0, 9, 1);
    load(1, 9, 1);
    expect_f(0, 9, 1);
    expect_f(1, 9, 1);
    release_reset();
    @(negedge clk);
    check("t6_restart_locked", 64'(bus.locked), 64'd1);
    check("t6_restart_grant0", 64'(bus.grant), 64'd0);
    wait_drain("t6_drain", 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
